// File: rtl/seq_divider_16bit.sv
// -----------------------------------------------------------------------------
// seq_divider_16bit
//
// Sequential unsigned restoring divider. One quotient bit is produced per
// clock, MSB first, so a division takes WIDTH cycles in RUN. A single DONE
// cycle follows. A zero divisor skips RUN and goes straight to DONE with a
// saturated quotient.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : division request, honoured only while idle
//   dividend     : unsigned dividend, captured with an accepted start
//   divisor      : unsigned divisor, captured with an accepted start
//   busy         : high while iterations run
//   done         : one-cycle pulse, results valid
//   quotient     : registered quotient (all ones on divide by zero)
//   remainder    : registered remainder (dividend on divide by zero)
//   div_by_zero  : registered flag, divisor of last completed op was zero
// -----------------------------------------------------------------------------
module seq_divider_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Working registers. acc holds the dividend, which shifts out at the MSB
    // while quotient bits shift in at the LSB; after WIDTH iterations it
    // holds the full quotient.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Result registers, written only on the edge that enters DONE.
    logic [WIDTH-1:0] quo_res_q, quo_res_d;
    logic [WIDTH-1:0] rem_res_q, rem_res_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] acc_next;
    logic             unused_trial_bit;

    assign accept       = (state_q == IDLE) && start;
    assign divisor_zero = (divisor == '0);

    // One restoring step: bring in the next dividend bit, trial-subtract the
    // divisor over WIDTH+1 bits and look at the borrow out.
    assign shifted  = {rem_q, acc_q[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
    assign borrow   = trial[WIDTH+1];
    assign q_bit    = ~borrow;
    assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign acc_next = {acc_q[WIDTH-2:0], q_bit};

    // When no borrow occurs the difference is below the divisor, so bit
    // WIDTH of the difference is always zero and carries no information.
    assign unused_trial_bit = trial[WIDTH];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign quotient    = quo_res_q;
    assign remainder   = rem_res_q;
    assign div_by_zero = dbz_q;

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d     = acc_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quo_res_d = quo_res_q;
        rem_res_d = rem_res_q;
        dbz_d     = dbz_q;

        if (accept) begin
            acc_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = '0;
            // Divide by zero completes on this same edge.
            if (divisor_zero) begin
                quo_res_d = '1;
                rem_res_d = dividend;
                dbz_d     = 1'b1;
            end
        end else if (state_q == RUN) begin
            acc_d = acc_next;
            rem_d = rem_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                // Results are taken from the final step's combinational
                // outputs so they land on the edge that enters DONE.
                quo_res_d = acc_next;
                rem_res_d = rem_next;
                dbz_d     = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quo_res_q <= quo_res_d;
            rem_res_q <= rem_res_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider_16bit.sv
module tb_seq_divider_16bit;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[9];

    seq_divider_16bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, saturating on a zero divisor.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called at cycle 0 (just after a rising edge, DUT idle). Returns just
    // after the cycle following done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string nm);
        int done_cyc;
        int busy_cnt;
        int first_busy;
        bit overlap;
        done_cyc   = -1;
        busy_cnt   = 0;
        first_busy = -1;
        overlap    = 1'b0;

        start    = 1'b1;
        dividend = a;
        divisor  = b;
        next_cycle();
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);

        for (int c = 1; c <= W + 4; c++) begin
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
            end
            if (busy && done) overlap = 1'b1;
            if (done) begin
                done_cyc = c;
                break;
            end
            next_cycle();
        end

        chk({nm, ".done_cycle"}, done_cyc, (b == 0) ? 1 : W + 1);
        chk({nm, ".busy_cycles"}, busy_cnt, (b == 0) ? 0 : W);
        chk({nm, ".first_busy"}, first_busy, (b == 0) ? -1 : 1);
        chk({nm, ".busy_done_overlap"}, int'(overlap), 0);
        chk({nm, ".quotient"}, int'(quotient), int'(eq));
        chk({nm, ".remainder"}, int'(remainder), int'(er));
        chk({nm, ".div_by_zero"}, int'(div_by_zero), int'(ez));
        next_cycle();
        chk({nm, ".done_pulse_width"}, int'(done), 0);
    endtask

    initial begin
        int dcnt;
        int dcyc;
        int bcnt;
        logic [W-1:0] ra, rb, rq, rr;
        logic rz;

        vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    1'b0};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0};
        vecs[3] = '{16'd5,     16'd0,      16'hFFFF,   16'd5,    1'b1};
        vecs[4] = '{16'd9,     16'd3,      16'd3,      16'd0,    1'b0};
        vecs[5] = '{16'd3,     16'd10,     16'd0,      16'd3,    1'b0};
        vecs[6] = '{16'd1000,  16'd3,      16'd333,    16'd1,    1'b0};
        vecs[7] = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0};
        vecs[8] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,    1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.quotient", int'(quotient), 0);
        chk("reset.remainder", int'(remainder), 0);
        chk("reset.div_by_zero", int'(div_by_zero), 0);

        // Release mid-cycle; the very next edge must accept the first start.
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            ra  = 16'($urandom);
            if (sel == 0) begin
                rb = '0;
            end else if (sel <= 3) begin
                rb = 16'($urandom_range(1, 15));
            end else if (sel <= 7) begin
                rb = 16'($urandom_range(1, 65535));
            end else begin
                rb = 16'($urandom_range(256, 65535));
                ra = 16'($urandom_range(0, int'(rb) - 1));
            end
            ref_div(ra, rb, rq, rr, rz);
            run_op(ra, rb, rq, rr, rz, $sformatf("rnd%0d_%0d_%0d", i, ra, rb));
        end

        // Starts during RUN (cycle 5) and DONE (cycle 17) must be dropped.
        dcnt = 0;
        dcyc = -1;
        bcnt = 0;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) begin
                if (done) begin
                    dcnt++;
                    dcyc = c;
                end
                if (busy) bcnt++;
            end
            start    = (c == 0 || c == 5 || c == 17);
            dividend = (c == 0) ? 16'd100 : 16'd50;
            divisor  = (c == 0) ? 16'd7 : 16'd5;
            next_cycle();
        end
        start = 1'b0;
        chk("ignore.done_count", dcnt, 1);
        chk("ignore.done_cycle", dcyc, W + 1);
        chk("ignore.busy_cycles", bcnt, W);
        chk("ignore.quotient_held", int'(quotient), 14);
        chk("ignore.remainder_held", int'(remainder), 2);
        chk("ignore.div_by_zero_held", int'(div_by_zero), 0);

        // Reset in cycle 8 of a 1000/3 run.
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        next_cycle();
        start = 1'b0;
        repeat (7) next_cycle();
        chk("abort.busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.quotient", int'(quotient), 0);
        chk("abort.remainder", int'(remainder), 0);
        chk("abort.div_by_zero", int'(div_by_zero), 0);
        dcnt = 0;
        repeat (3) begin
            next_cycle();
            if (done || busy) dcnt++;
        end
        rst_n = 1'b1;
        chk("abort.no_activity_in_reset", dcnt, 0);
        dcnt = 0;
        repeat (W + 3) begin
            next_cycle();
            if (done) dcnt++;
        end
        chk("abort.no_late_done", dcnt, 0);
        run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_divider_16bit.md
SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; sampled with an accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; sampled with an accepted start.
REQ-007 SHALL have port busy  output  1  high while iterations are in progress (RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; divisor was zero for the last completed operation.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-013 IDLE: when start=1, SHALL latch the operands and go to RUN; if the divisor is zero, SHALL go to DONE instead.
REQ-014 RUN: SHALL execute exactly WIDTH restoring-division iterations, one per clock, MSB first.
REQ-015 Each iteration SHALL shift {partial remainder, dividend bit} left; trial-subtract the divisor using a WIDTH+1-bit subtract; on no borrow keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-016 The iteration counter SHALL run 0..WIDTH-1; the edge that completes iteration WIDTH-1 SHALL move the FSM to DONE.
REQ-017 DONE: SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: for a start accepted in cycle 0, busy SHALL be high in cycles 1..WIDTH and done high in cycle WIDTH+1.
REQ-019 Latency: for a divide by zero accepted in cycle 0, busy SHALL stay low and done SHALL be high in cycle 1.
REQ-020 Divide by zero SHALL produce quotient = all ones, remainder = latched dividend, div_by_zero = 1.
REQ-021 A normal completion SHALL clear div_by_zero.
REQ-022 quotient, remainder and div_by_zero SHALL update only on the edge entering DONE, and hold until the next completion.
REQ-023 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-024 Operand input changes after acceptance SHALL NOT affect the result.
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all nonzero divisors.
REQ-026 busy and done SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced for it.
REQ-029 The first start after rst_n is released SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-030 100/7, start in cycle 0 -> busy in cycles 1..16; done in cycle 17 with quotient=14, remainder=2, div_by_zero=0.
REQ-031 0xFFFF/1 -> quotient=0xFFFF, remainder=0; 0xFFFF/0xFFFF -> quotient=1, remainder=0.
REQ-032 5/0 -> done in cycle 1, busy never high, quotient=0xFFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-033 3/10 -> quotient=0, remainder=3.
REQ-034 Start 100/7, then start=1 with 50/5 in cycles 5 and 17 -> both ignored; only 14 r 2 is reported; outputs hold afterwards.
REQ-035 Start 1000/3, rst_n low in cycle 8 -> outputs zero immediately, no done pulse; after release, 1000/3 -> quotient=333, remainder=1.
